// File: rtl/aes_round_mix_stage.sv
// AES-128 encrypt round back-end: ShiftRows -> MixColumns (bypassed on the
// final round) -> AddRoundKey, registered behind a valid/ready handshake.
// Optional build macro: AES_STAGE_SKID_EN adds a one-entry skid buffer so that
// in_ready becomes a register output instead of a combinational path from
// out_ready.
module aes_round_mix_stage #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_state,
  input  logic [127:0]     in_key,
  input  logic             in_last,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_state,
  output logic             out_last,
  output logic [TAG_W-1:0] out_tag
);

  // GF(2^8) multiply-by-2 with reduction polynomial 0x11B
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  logic [7:0]   w_in_b  [16];
  logic [7:0]   w_sr_b  [16];
  logic [7:0]   w_mc_b  [16];
  logic [127:0] w_result;
  logic         w_in_fire;
  logic         w_out_fire;

  logic             r_out_valid;
  logic [127:0]     r_out_state;
  logic             r_out_last;
  logic [TAG_W-1:0] r_out_tag;

  // Unpack the state into FIPS byte order: byte k lives at [127-8k -: 8]
  always_comb begin
    for (int unsigned k = 0; k < 16; k++) begin
      w_in_b[k] = in_state[127-8*k -: 8];
    end
  end

  // ShiftRows: s'[r][c] = s[r][(c+r) mod 4], byte index r+4c
  always_comb begin
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        w_sr_b[r+4*c] = w_in_b[r+4*((c+r)%4)];
      end
    end
  end

  // MixColumns: each output byte = 2*a[r] ^ 3*a[r+1] ^ a[r+2] ^ a[r+3]
  always_comb begin
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        w_mc_b[r+4*c] = xtime(w_sr_b[r+4*c])
                      ^ xtime(w_sr_b[((r+1)%4)+4*c]) ^ w_sr_b[((r+1)%4)+4*c]
                      ^ w_sr_b[((r+2)%4)+4*c]
                      ^ w_sr_b[((r+3)%4)+4*c];
      end
    end
  end

  // AddRoundKey on either the mixed or the merely shifted state
  always_comb begin
    w_result = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      w_result[127-8*k -: 8] = (in_last ? w_sr_b[k] : w_mc_b[k]) ^ in_key[127-8*k -: 8];
    end
  end

  assign w_out_fire = r_out_valid && out_ready;
  assign w_in_fire  = in_valid && in_ready;

`ifdef AES_STAGE_SKID_EN

  logic             r_in_ready;
  logic             r_skid_valid;
  logic [127:0]     r_skid_state;
  logic             r_skid_last;
  logic [TAG_W-1:0] r_skid_tag;
  logic             w_out_free;

  // r_in_ready mirrors "skid empty"; it resets to 1 so the first cycle after
  // reset can accept, and rst masks it while reset is held.
  assign in_ready   = r_in_ready && !rst;
  assign w_out_free = !r_out_valid || out_ready;

  // Output register plus one-entry skid: fill when stalled, drain on next out transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_state  <= '0;
      r_out_last   <= 1'b0;
      r_out_tag    <= '0;
      r_skid_valid <= 1'b0;
      r_skid_state <= '0;
      r_skid_last  <= 1'b0;
      r_skid_tag   <= '0;
      r_in_ready   <= 1'b1;
    end else if (r_skid_valid) begin
      if (w_out_fire) begin
        r_out_state  <= r_skid_state;
        r_out_last   <= r_skid_last;
        r_out_tag    <= r_skid_tag;
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b1;
      end
    end else if (w_in_fire) begin
      if (w_out_free) begin
        r_out_valid <= 1'b1;
        r_out_state <= w_result;
        r_out_last  <= in_last;
        r_out_tag   <= in_tag;
      end else begin
        r_skid_valid <= 1'b1;
        r_skid_state <= w_result;
        r_skid_last  <= in_last;
        r_skid_tag   <= in_tag;
        r_in_ready   <= 1'b0;
      end
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
    end
  end

`else

  assign in_ready = !rst && (!r_out_valid || out_ready);

  // Single output register: load on accept, clear valid once consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_state <= '0;
      r_out_last  <= 1'b0;
      r_out_tag   <= '0;
    end else if (w_in_fire) begin
      r_out_valid <= 1'b1;
      r_out_state <= w_result;
      r_out_last  <= in_last;
      r_out_tag   <= in_tag;
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
    end
  end

`endif

  assign out_valid = r_out_valid;
  assign out_state = r_out_state;
  assign out_last  = r_out_last;
  assign out_tag   = r_out_tag;

endmodule
